mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer that shares the single main-memory word port between the instruction-cache refill path and the data-cache refill/writeback path. Each granted request moves one full cache line as LINE_WORDS single-word beats. The block provides round-robin fairness, per-beat data forwarding and a one-cycle completion pulse per requester. It sits beneath the fetch and memory stages, and its `busy` output feeds the pipeline stall logic.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 32, byte address width.
- `LINE_WORDS`, 4, words per line; power of two, ≥2. `OFF = $clog2(LINE_WORDS)+2`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  1  I-side line read request; held until `i_done`.
- `i_addr`  in  ADDR_WIDTH  I-side byte address; any alignment.
- `i_rdata`  out  DATA_WIDTH  read word to I-side.
- `i_rvalid`  out  1  `i_rdata` valid this cycle.
- `i_word_idx`  out  $clog2(LINE_WORDS)  current beat index.
- `i_done`  out  1  one-cycle line-complete pulse.
- `d_req`  in  1  D-side line request; held until `d_done`.
- `d_we`  in  1  1 = line writeback, 0 = line refill; stable while `d_req` is high.
- `d_addr`  in  ADDR_WIDTH  D-side byte address.
- `d_wdata`  in  DATA_WIDTH  writeback word for index `d_word_idx`; combinational from the cache.
- `d_rdata`, `d_rvalid`, `d_word_idx`, `d_done`: D-side equivalents of the I-side outputs.
- `mem_req`  out  1  memory beat request.
- `mem_we`  out  1  beat is a write.
- `mem_addr`  out  ADDR_WIDTH  word-aligned beat address.
- `mem_wdata`  out  DATA_WIDTH  write word.
- `mem_ack`  in  1  beat complete: read data valid, or write accepted.
- `mem_rdata`  in  DATA_WIDTH  read word, valid with `mem_ack`.
- `busy`  out  1  state ≠ IDLE.
- `grant_i`, `grant_d`  out  1  current owner; one-hot or zero.

## Operation
- States:
  - IDLE: no owner.
  - XFER: beats in progress.
  - DONE: completion pulse.
- Registers:
  - `state`
  - `owner` (I/D)
  - `last_grant` (I/D)
  - `base` (ADDR_WIDTH−OFF bits)
  - `we_q`
  - `beat` ($clog2(LINE_WORDS) bits)
- IDLE:
  - If exactly one request is high, that side wins.
  - If both are high, the side ≠ `last_grant` wins.
  - On a win: latch `base = addr[ADDR_WIDTH-1:OFF]`, `we_q` (= `d_we` for D, 0 for I), `beat = 0`, set `owner` and `last_grant`, then go to XFER.
- XFER:
  - `mem_req = 1`, `mem_we = we_q`, `mem_addr = {base, beat, 2'b00}`, `mem_wdata = d_wdata`.
  - `d_word_idx` / `i_word_idx = beat`.
  - On `mem_ack`: if `!we_q`, the owner's `rvalid = 1` with `rdata = mem_rdata` in the same cycle. Then `beat++`.
  - An ack with `beat == LINE_WORDS-1` goes to DONE, and `beat` wraps to 0.
  - Without an ack, all XFER outputs hold.
- DONE: owner's `done = 1` for exactly this cycle, then IDLE. Requests are not sampled in DONE.
- Requesters drop `req` in the IDLE cycle following `done`. A req still high in that cycle starts a new transaction.
- Non-owner `rvalid`/`done` are always 0. `rdata` buses may carry `mem_rdata` unconditionally.
- Low OFF address bits are ignored; the line always starts at beat 0.

## Timing
- Reset:
  - state IDLE, `beat` 0, `owner` I, `last_grant` D, so the first tie goes to I.
  - All outputs 0: `mem_req`, `mem_we`, `busy`, grants, rvalids, dones.
  - `mem_addr`/`mem_wdata` are 0 in IDLE.
- Reset mid-transaction: the transaction is abandoned with no `done`; IDLE on the next cycle; the requester must re-request.
- `rst` high overrides requests and `mem_ack` in the same cycle.
- Latency:
  - req sampled in IDLE at cycle 0, `mem_req` first high at cycle 1.
  - With a zero-wait memory (`mem_ack` held high), beats occupy cycles 1..LINE_WORDS, `done` at cycle LINE_WORDS+1, IDLE at LINE_WORDS+2.
  - For LINE_WORDS=4: 6 cycles per line, plus memory wait cycles.
- Back-to-back lines are separated by at least one IDLE cycle.
- `busy` is registered from state. The rvalid and mem-side outputs are combinational from state plus `mem_ack`.

## Test plan
- I refill, `i_addr = 0x0000_1234`, `mem_ack` always 1, `mem_rdata = addr`:
  - `mem_addr` must be 0x1230, 0x1234, 0x1238, 0x123C on cycles 1–4.
  - `i_rvalid` must be high on cycles 1–4 with matching data.
  - `i_done` must pulse at cycle 5.
- D writeback, `d_addr = 0x2000`, `d_we = 1`, `d_wdata = 0xA0+idx`, `mem_ack` every other cycle:
  - `mem_we = 1` with wdata 0xA0..0xA3.
  - `d_rvalid` must never assert.
  - `d_done` after the 4th ack.
- Tie after reset (both req high): I must be granted first.
- Tie immediately after that I line completes: D must be granted next.
- D refill with `mem_ack` low for 3 cycles per beat: `mem_addr` and `d_word_idx` must stay stable until each ack, and the line completes after 16 XFER cycles.
- `rst` asserted at beat 2 of an I refill:
  - Next cycle: IDLE, `mem_req = 0`, no `i_done`.
  - A re-issued request restarts at beat 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns / 1ps
// mem_arbiter: shares one main-memory word port between the I-cache refill path and
// the D-cache refill/writeback path. A grant moves one whole line as LINE_WORDS
// single-word beats, with round-robin fairness on ties.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_req, i_addr             I-side line read request and byte address
//   i_rdata, i_rvalid         I-side read word and per-beat valid
//   i_word_idx, i_done        I-side beat index and line-complete pulse
//   d_req, d_we, d_addr       D-side line request, writeback flag, byte address
//   d_wdata                   D-side writeback word for index d_word_idx
//   d_rdata, d_rvalid         D-side read word and per-beat valid
//   d_word_idx, d_done        D-side beat index and line-complete pulse
//   mem_req, mem_we           memory beat request and write flag
//   mem_addr, mem_wdata       word-aligned beat address and write word
//   mem_ack, mem_rdata        beat complete and read word
//   busy                      arbiter is not idle (feeds pipeline stall)
//   grant_i, grant_d          current owner, one-hot or zero
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  output logic [DATA_WIDTH-1:0]         i_rdata,
  output logic                          i_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] i_word_idx,
  output logic                          i_done,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_WIDTH-1:0]         d_addr,
  input  logic [DATA_WIDTH-1:0]         d_wdata,
  output logic [DATA_WIDTH-1:0]         d_rdata,
  output logic                          d_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] d_word_idx,
  output logic                          d_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_ack,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          busy,
  output logic                          grant_i,
  output logic                          grant_d
);

  localparam int unsigned BeatW = $clog2(LINE_WORDS);
  localparam int unsigned Off   = BeatW + 2;
  localparam int unsigned BaseW = ADDR_WIDTH - Off;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;
  typedef enum logic {OwnI = 1'b0, OwnD = 1'b1} owner_e;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_grant_q, last_grant_d;
  logic [BaseW-1:0] base_q, base_d;
  logic             we_q, we_d;
  logic [BeatW-1:0] beat_q, beat_d;

  // Line offset bits are deliberately dropped: every line starts at beat 0.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{i_addr[Off-1:0], d_addr[Off-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnI;
      last_grant_q <= OwnD;  // first tie after reset goes to I
      base_q       <= '0;
      we_q         <= 1'b0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      we_q         <= we_d;
      beat_q       <= beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    we_d         = we_q;
    beat_d       = beat_q;
    unique case (state_q)
      StIdle: begin
        if (i_req && (!d_req || last_grant_q == OwnD)) begin
          state_d      = StXfer;
          owner_d      = OwnI;
          last_grant_d = OwnI;
          base_d       = i_addr[ADDR_WIDTH-1:Off];
          we_d         = 1'b0;
          beat_d       = '0;
        end else if (d_req) begin
          state_d      = StXfer;
          owner_d      = OwnD;
          last_grant_d = OwnD;
          base_d       = d_addr[ADDR_WIDTH-1:Off];
          we_d         = d_we;
          beat_d       = '0;
        end
      end
      StXfer: begin
        if (mem_ack) begin
          beat_d = beat_q + BeatW'(1);  // wraps to 0 after the last beat
          if (beat_q == LastBeat) begin
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic in_xfer, in_done, rd_beat;

  always_comb begin
    in_xfer   = (state_q == StXfer);
    in_done   = (state_q == StDone);
    rd_beat   = in_xfer && mem_ack && !we_q;

    busy      = (state_q != StIdle);
    grant_i   = busy && (owner_q == OwnI);
    grant_d   = busy && (owner_q == OwnD);

    mem_req   = in_xfer;
    mem_we    = in_xfer && we_q;
    mem_addr  = in_xfer ? {base_q, beat_q, 2'b00} : '0;
    mem_wdata = in_xfer ? d_wdata : '0;

    i_rdata    = mem_rdata;
    d_rdata    = mem_rdata;
    i_rvalid   = rd_beat && (owner_q == OwnI);
    d_rvalid   = rd_beat && (owner_q == OwnD);
    i_word_idx = beat_q;
    d_word_idx = beat_q;
    i_done     = in_done && (owner_q == OwnI);
    d_done     = in_done && (owner_q == OwnD);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns / 1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_rvalid, i_done, d_rvalid, d_done;
  logic [1:0]  i_word_idx, d_word_idx;
  logic        mem_req, mem_we, busy, grant_i, grant_d;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory returns its address as read data; the D-cache supplies 0xA0 + index.
  assign mem_rdata = mem_addr;
  assign d_wdata   = 32'h0000_00A0 + 32'(d_word_idx);

  mem_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .LINE_WORDS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_rvalid  (i_rvalid),
    .i_word_idx(i_word_idx),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_rvalid  (d_rvalid),
    .d_word_idx(d_word_idx),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  typedef struct {
    logic        ireq, dreq, dwe, ack;
    logic [31:0] iaddr, daddr;
    logic        mreq, mwe;
    logic [31:0] maddr;
    logic        irv, idn, drv, ddn, bsy, gi, gd;
    logic [1:0]  idx;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(int ireq, int dreq, int dwe, int ack, int iaddr, int daddr,
                              int mreq, int mwe, int maddr, int irv, int idn, int drv,
                              int ddn, int bsy, int gi, int gd, int idx);
    vec_t v;
    v.ireq = 1'(ireq);  v.dreq = 1'(dreq);  v.dwe = 1'(dwe);  v.ack = 1'(ack);
    v.iaddr = 32'(iaddr);  v.daddr = 32'(daddr);
    v.mreq = 1'(mreq);  v.mwe = 1'(mwe);  v.maddr = 32'(maddr);
    v.irv = 1'(irv);  v.idn = 1'(idn);  v.drv = 1'(drv);  v.ddn = 1'(ddn);
    v.bsy = 1'(bsy);  v.gi = 1'(gi);  v.gd = 1'(gd);  v.idx = 2'(idx);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_beat;
    rst = 1'b1;  i_req = 1'b0;  d_req = 1'b0;  d_we = 1'b0;  mem_ack = 1'b0;
    i_addr = '0;  d_addr = '0;

    //          ireq dreq dwe ack iaddr   daddr   mreq mwe maddr  irv idn drv ddn bsy gi gd idx
    tbl[0]  = mk(1, 1, 0, 1, 'h1234, 'h4008, 0, 0, 'h0,    0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 'h1234, 'h4008, 1, 0, 'h1230, 1, 0, 0, 0, 1, 1, 0, 0);
    tbl[2]  = mk(1, 1, 0, 1, 'h1234, 'h4008, 1, 0, 'h1234, 1, 0, 0, 0, 1, 1, 0, 1);
    tbl[3]  = mk(1, 1, 0, 1, 'h1234, 'h4008, 1, 0, 'h1238, 1, 0, 0, 0, 1, 1, 0, 2);
    tbl[4]  = mk(1, 1, 0, 1, 'h1234, 'h4008, 1, 0, 'h123C, 1, 0, 0, 0, 1, 1, 0, 3);
    tbl[5]  = mk(1, 1, 0, 1, 'h1234, 'h4008, 0, 0, 'h0,    0, 1, 0, 0, 1, 1, 0, 0);
    tbl[6]  = mk(1, 1, 0, 1, 'h1234, 'h4008, 0, 0, 'h0,    0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 1, 'h1234, 'h4008, 1, 0, 'h4000, 0, 0, 1, 0, 1, 0, 1, 0);
    tbl[8]  = mk(1, 1, 0, 1, 'h1234, 'h4008, 1, 0, 'h4004, 0, 0, 1, 0, 1, 0, 1, 1);
    tbl[9]  = mk(1, 1, 0, 1, 'h1234, 'h4008, 1, 0, 'h4008, 0, 0, 1, 0, 1, 0, 1, 2);
    tbl[10] = mk(1, 1, 0, 1, 'h1234, 'h4008, 1, 0, 'h400C, 0, 0, 1, 0, 1, 0, 1, 3);
    tbl[11] = mk(1, 1, 0, 1, 'h1234, 'h4008, 0, 0, 'h0,    0, 0, 0, 1, 1, 0, 1, 0);
    tbl[12] = mk(1, 0, 0, 1, 'h1234, 'h4008, 0, 0, 'h0,    0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 1, 'h1234, 'h4008, 1, 0, 'h1230, 1, 0, 0, 0, 1, 1, 0, 0);
    tbl[14] = mk(1, 0, 0, 1, 'h1234, 'h4008, 1, 0, 'h1234, 1, 0, 0, 0, 1, 1, 0, 1);
    tbl[15] = mk(1, 0, 0, 1, 'h1234, 'h4008, 1, 0, 'h1238, 1, 0, 0, 0, 1, 1, 0, 2);
    tbl[16] = mk(1, 0, 0, 1, 'h1234, 'h4008, 1, 0, 'h123C, 1, 0, 0, 0, 1, 1, 0, 3);
    tbl[17] = mk(1, 0, 0, 1, 'h1234, 'h4008, 0, 0, 'h0,    0, 1, 0, 0, 1, 1, 0, 0);
    tbl[18] = mk(0, 0, 0, 1, 'h1234, 'h4008, 0, 0, 'h0,    0, 0, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 'h1234, 'h4008, 0, 0, 'h0,    0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst grants", 32'({grant_i, grant_d}), 32'd0);
    chk("rst valids", 32'({i_rvalid, d_rvalid, i_done, d_done}), 32'd0);
    chk("rst word_idx", 32'(i_word_idx), 32'd0);
    tick_drive();
    rst = 1'b0;

    // Tie after reset -> I line, tie after I done -> D line, then a lone I line
    for (int i = 0; i < 20; i++) begin
      tick_drive();
      i_req = tbl[i].ireq;  d_req = tbl[i].dreq;  d_we = tbl[i].dwe;
      mem_ack = tbl[i].ack;  i_addr = tbl[i].iaddr;  d_addr = tbl[i].daddr;
      @(negedge clk);
      chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(tbl[i].mreq));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(tbl[i].mwe));
      chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].maddr);
      chk($sformatf("v%0d i_rvalid", i), 32'(i_rvalid), 32'(tbl[i].irv));
      chk($sformatf("v%0d i_done", i), 32'(i_done), 32'(tbl[i].idn));
      chk($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'(tbl[i].drv));
      chk($sformatf("v%0d d_done", i), 32'(d_done), 32'(tbl[i].ddn));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("v%0d grant_i", i), 32'(grant_i), 32'(tbl[i].gi));
      chk($sformatf("v%0d grant_d", i), 32'(grant_d), 32'(tbl[i].gd));
      chk($sformatf("v%0d i_word_idx", i), 32'(i_word_idx), 32'(tbl[i].idx));
      chk($sformatf("v%0d d_word_idx", i), 32'(d_word_idx), 32'(tbl[i].idx));
      if (tbl[i].irv) chk($sformatf("v%0d i_rdata", i), i_rdata, tbl[i].maddr);
      if (tbl[i].drv) chk($sformatf("v%0d d_rdata", i), d_rdata, tbl[i].maddr);
    end

    // D writeback, ack every other cycle
    tick_drive();
    d_req = 1'b1;  d_we = 1'b1;  d_addr = 32'h2000;  mem_ack = 1'b0;
    exp_beat = 0;
    for (int c = 0; c < 8; c++) begin
      tick_drive();
      mem_ack = (c % 2 == 1);
      @(negedge clk);
      chk($sformatf("wb%0d mem_req", c), 32'(mem_req), 32'd1);
      chk($sformatf("wb%0d mem_we", c), 32'(mem_we), 32'd1);
      chk($sformatf("wb%0d mem_addr", c), mem_addr, 32'(32'h2000 + 4 * exp_beat));
      chk($sformatf("wb%0d mem_wdata", c), mem_wdata, 32'(32'hA0 + exp_beat));
      chk($sformatf("wb%0d d_rvalid", c), 32'(d_rvalid), 32'd0);
      chk($sformatf("wb%0d d_done", c), 32'(d_done), 32'd0);
      if (mem_ack) exp_beat++;
    end
    tick_drive();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("wb d_done", 32'(d_done), 32'd1);
    chk("wb done d_rvalid", 32'(d_rvalid), 32'd0);
    chk("wb done mem_req", 32'(mem_req), 32'd0);
    tick_drive();
    d_req = 1'b0;  d_we = 1'b0;
    @(negedge clk);
    chk("wb idle busy", 32'(busy), 32'd0);

    // D refill with three wait cycles per beat: 16 XFER cycles
    tick_drive();
    d_req = 1'b1;  d_we = 1'b0;  d_addr = 32'h3000;  mem_ack = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick_drive();
      mem_ack = (c % 4 == 3);
      @(negedge clk);
      chk($sformatf("ws%0d mem_addr", c), mem_addr, 32'(32'h3000 + 4 * (c / 4)));
      chk($sformatf("ws%0d d_word_idx", c), 32'(d_word_idx), 32'(c / 4));
      chk($sformatf("ws%0d mem_we", c), 32'(mem_we), 32'd0);
      chk($sformatf("ws%0d d_rvalid", c), 32'(d_rvalid), 32'(c % 4 == 3));
      chk($sformatf("ws%0d d_done", c), 32'(d_done), 32'd0);
      if (c % 4 == 3) chk($sformatf("ws%0d d_rdata", c), d_rdata, 32'(32'h3000 + 4 * (c / 4)));
    end
    tick_drive();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("ws d_done", 32'(d_done), 32'd1);
    tick_drive();
    d_req = 1'b0;

    // Reset at beat 2 of an I refill, then restart from beat 0
    tick_drive();
    i_req = 1'b1;  i_addr = 32'h1234;  mem_ack = 1'b1;
    repeat (2) tick_drive();
    tick_drive();
    rst = 1'b1;
    @(negedge clk);
    chk("rr beat2 mem_addr", mem_addr, 32'h1238);
    tick_drive();
    rst = 1'b0;
    @(negedge clk);
    chk("rr busy", 32'(busy), 32'd0);
    chk("rr mem_req", 32'(mem_req), 32'd0);
    chk("rr i_done", 32'(i_done), 32'd0);
    chk("rr i_rvalid", 32'(i_rvalid), 32'd0);
    tick_drive();
    @(negedge clk);
    chk("rr restart mem_addr", mem_addr, 32'h1230);
    chk("rr restart idx", 32'(i_word_idx), 32'd0);
    chk("rr restart grant_i", 32'(grant_i), 32'd1);
    repeat (3) tick_drive();
    @(negedge clk);
    chk("rr last mem_addr", mem_addr, 32'h123C);
    tick_drive();
    @(negedge clk);
    chk("rr i_done", 32'(i_done), 32'd1);
    tick_drive();
    i_req = 1'b0;  mem_ack = 1'b0;
    @(negedge clk);
    chk("rr end busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
